ex_stage: RTL and testbench
===========================

Name: ex_stage

Overview:
- Execute stage of the 5-stage RV32IM pipeline. It sits directly downstream of the ID/EX pipeline register and consumes its outputs.
- Computes ALU results, resolves branches and jumps, and runs DIV/DIVU/REM/REMU on an iterative radix-2 divider.
- Registers everything it produces toward the MEM stage.
- Raises stall_o while the divider is busy so that PC, IF/ID and ID/EX hold their contents.

Parameters:
DIV_ENABLE, 1, 1 = iterative divider present; 0 = divide opcodes yield result 0 in a single cycle with no stall

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-high reset
pc_i  input  32  instruction PC from ID/EX
rs1_i  input  32  rs1 operand
rs2_i  input  32  rs2 operand
br_sig_i  input  1  instruction is a branch or jump
br_op_i  input  3  0 BEQ, 1 BNE, 2 JAL, 3 JALR, 4 BLT, 5 BGE, 6 BLTU, 7 BGEU
lsu_op_i  input  3  load/store type, passed through
alu_op_i  input  5  0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 SLTU, 5 XOR, 6 SRL, 7 SRA, 8 OR, 9 AND, 10 PASS_B, 14 DIV, 15 DIVU, 16 REM, 17 REMU; all other codes yield 0
data_origin_i  input  2  bit1: opA = pc (else rs1); bit0: opB = imm (else rs2)
data_dest_i  input  2  writeback source select, passed through
imm_i  input  32  immediate
reg_wr_addr_i  input  5  destination register
reg_wr_sig_i  input  1  register write enable
mem_wr_sig_i  input  1  memory write enable
stall_o  output  1  combinational; high holds the upstream stages
alu_result_o  output  32  registered result
store_data_o  output  32  registered rs2_i
lsu_op_o  output  3  registered
data_dest_o  output  2  registered
reg_wr_addr_o  output  5  registered
reg_wr_sig_o  output  1  registered
mem_wr_sig_o  output  1  registered
br_taken_o  output  1  registered; redirect fetch and flush younger instructions
br_target_o  output  32  registered redirect address

Behaviour:
- Reset:
  - All registered outputs are 0.
  - The FSM goes to IDLE and the divider count to 0.
  - stall_o is 0.
  - Reset asserted mid-divide aborts the divide and discards it.
- Shift operations use opB[4:0]. SLT/SLTU yield 0 or 1. PASS_B outputs opB (LUI/AUIPC use).
- Branch condition compares rs1_i against rs2_i (never the muxed operands). Signed/unsigned per br_op.
- Targets:
  - Conditional branches and JAL: pc_i + imm_i.
  - JALR: (rs1_i + imm_i) & ~1.
- br_taken is br_sig_i AND condition. JAL/JALR are always taken.
- For JAL/JALR, alu_result_o = pc_i + 4, overriding alu_op.
- Single-cycle operations: outputs update on the next rising edge, latency 1. stall_o stays 0.
- Divider FSM, states IDLE / BUSY / DONE:
  - IDLE with a divide alu_op (DIV_ENABLE = 1):
    - stall_o = 1 in the same cycle.
    - Latch |opA| and |opB| plus sign flags (unsigned ops take raw values).
    - Clear count. Go to BUSY.
  - BUSY:
    - stall_o = 1.
    - One restoring shift-subtract step per cycle.
    - After step 31 (32 steps total), go to DONE.
  - DONE:
    - stall_o = 0.
    - Apply sign correction. The output register captures the quotient or remainder together with the held control fields.
    - Return to IDLE. The DONE state prevents the same held instruction from restarting the divide.
  - Total latency: 34 cycles from first presentation to output register update. stall_o is high for 33 cycles.
- While stall_o = 1, the output register loads a bubble:
  - reg_wr_sig_o = 0, mem_wr_sig_o = 0, br_taken_o = 0.
  - Other output fields are don't-care; hold them at 0.
- Divide corner cases (same 34-cycle latency, RISC-V semantics):
  - Divisor 0: quotient 0xFFFFFFFF, remainder = dividend.
  - DIV/REM of 0x80000000 by 0xFFFFFFFF: quotient 0x80000000, remainder 0.
  - Remainder takes the sign of the dividend.
- A bubble input (all write/branch enables 0) produces a bubble output. The block has no separate valid signal.

Test Plan:
- opA=rs1=5, opB=imm=0xFFFFFFFD, ADD, reg_wr_sig=1, rd=3 -> next cycle alu_result_o=2, reg_wr_addr_o=3, reg_wr_sig_o=1, stall_o never high.
- BLT with rs1=0xFFFFFFFF (-1), rs2=1, pc=0x100, imm=0x20 -> br_taken_o=1, br_target_o=0x120. Same stimulus with BLTU -> br_taken_o=0.
- JALR with rs1=0x1003, imm=4, pc=0x40 -> br_target_o=0x1006, alu_result_o=0x44, br_taken_o=1.
- DIVU 100/7 held by the bench while stall_o=1 -> stall_o high for exactly 33 cycles with bubbles emitted; alu_result_o=14 on cycle 34. REMU under the same stimulus -> 2.
- DIV by 0 of -7 -> 0xFFFFFFFF. REM of 0x80000000 by -1 -> 0. DIV of -7 by 2 -> 0xFFFFFFFD. REM of -7 by 2 -> 0xFFFFFFFF.
- Assert reset during BUSY at step 10 -> all outputs 0 and stall_o 0 immediately. After release, an ADD completes in 1 cycle.

Source files
------------

// File: rtl/ex_stage.sv
// Execute stage of the RV32IM pipeline: ALU, branch resolution, iterative radix-2
// divider, and the EX/MEM output register.
module ex_stage #(
    parameter bit DIV_ENABLE = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pc_i,
    input  logic [31:0] rs1_i,
    input  logic [31:0] rs2_i,
    input  logic        br_sig_i,
    input  logic [2:0]  br_op_i,
    input  logic [2:0]  lsu_op_i,
    input  logic [4:0]  alu_op_i,
    input  logic [1:0]  data_origin_i,
    input  logic [1:0]  data_dest_i,
    input  logic [31:0] imm_i,
    input  logic [4:0]  reg_wr_addr_i,
    input  logic        reg_wr_sig_i,
    input  logic        mem_wr_sig_i,
    output logic        stall_o,
    output logic [31:0] alu_result_o,
    output logic [31:0] store_data_o,
    output logic [2:0]  lsu_op_o,
    output logic [1:0]  data_dest_o,
    output logic [4:0]  reg_wr_addr_o,
    output logic        reg_wr_sig_o,
    output logic        mem_wr_sig_o,
    output logic        br_taken_o,
    output logic [31:0] br_target_o
);

    localparam int unsigned XLEN  = 32;
    localparam int unsigned CNT_W = 5;

    localparam logic [4:0] OP_ADD  = 5'd0;
    localparam logic [4:0] OP_SUB  = 5'd1;
    localparam logic [4:0] OP_SLL  = 5'd2;
    localparam logic [4:0] OP_SLT  = 5'd3;
    localparam logic [4:0] OP_SLTU = 5'd4;
    localparam logic [4:0] OP_XOR  = 5'd5;
    localparam logic [4:0] OP_SRL  = 5'd6;
    localparam logic [4:0] OP_SRA  = 5'd7;
    localparam logic [4:0] OP_OR   = 5'd8;
    localparam logic [4:0] OP_AND  = 5'd9;
    localparam logic [4:0] OP_PASS = 5'd10;
    localparam logic [4:0] OP_DIV  = 5'd14;
    localparam logic [4:0] OP_DIVU = 5'd15;
    localparam logic [4:0] OP_REM  = 5'd16;
    localparam logic [4:0] OP_REMU = 5'd17;

    localparam logic [2:0] BR_BEQ  = 3'd0;
    localparam logic [2:0] BR_BNE  = 3'd1;
    localparam logic [2:0] BR_JAL  = 3'd2;
    localparam logic [2:0] BR_JALR = 3'd3;
    localparam logic [2:0] BR_BLT  = 3'd4;
    localparam logic [2:0] BR_BGE  = 3'd5;
    localparam logic [2:0] BR_BLTU = 3'd6;
    localparam logic [2:0] BR_BGEU = 3'd7;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } div_state_e;

    div_state_e          state_q, state_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic [XLEN-1:0]     quo_q, quo_d;
    logic [XLEN-1:0]     rem_q, rem_d;
    logic [XLEN-1:0]     dvsr_q, dvsr_d;
    logic                qneg_q, qneg_d;
    logic                rneg_q, rneg_d;

    logic [XLEN-1:0]     alu_result_d, store_data_d, br_target_d;
    logic [2:0]          lsu_op_d;
    logic [1:0]          data_dest_d;
    logic [4:0]          reg_wr_addr_d;
    logic                reg_wr_sig_d, mem_wr_sig_d, br_taken_d;

    logic [XLEN-1:0]     op_a, op_b, alu_val;
    logic                is_div, signed_div, is_rem, is_link, br_cond;
    logic [XLEN-1:0]     abs_a, abs_b;
    logic [XLEN:0]       r_shift;
    logic                r_ge;
    logic [XLEN-1:0]     r_sub, div_res;

    assign op_a = data_origin_i[1] ? pc_i  : rs1_i;
    assign op_b = data_origin_i[0] ? imm_i : rs2_i;

    assign is_div     = DIV_ENABLE && (alu_op_i == OP_DIV || alu_op_i == OP_DIVU ||
                                       alu_op_i == OP_REM || alu_op_i == OP_REMU);
    assign signed_div = (alu_op_i == OP_DIV) || (alu_op_i == OP_REM);
    assign is_rem     = (alu_op_i == OP_REM) || (alu_op_i == OP_REMU);
    assign is_link    = br_sig_i && (br_op_i == BR_JAL || br_op_i == BR_JALR);

    assign stall_o = !reset && ((state_q == S_IDLE && is_div) || state_q == S_BUSY);

    // Single-cycle ALU; divide opcodes fall to 0 here and are served by the divider.
    always_comb begin
        alu_val = '0;
        case (alu_op_i)
            OP_ADD:  alu_val = op_a + op_b;
            OP_SUB:  alu_val = op_a - op_b;
            OP_SLL:  alu_val = op_a << op_b[4:0];
            OP_SLT:  alu_val = XLEN'($signed(op_a) < $signed(op_b));
            OP_SLTU: alu_val = XLEN'(op_a < op_b);
            OP_XOR:  alu_val = op_a ^ op_b;
            OP_SRL:  alu_val = op_a >> op_b[4:0];
            OP_SRA:  alu_val = $unsigned($signed(op_a) >>> op_b[4:0]);
            OP_OR:   alu_val = op_a | op_b;
            OP_AND:  alu_val = op_a & op_b;
            OP_PASS: alu_val = op_b;
            default: alu_val = '0;
        endcase
    end

    // Branch condition always uses the raw register operands.
    always_comb begin
        br_cond = 1'b0;
        case (br_op_i)
            BR_BEQ:  br_cond = (rs1_i == rs2_i);
            BR_BNE:  br_cond = (rs1_i != rs2_i);
            BR_JAL:  br_cond = 1'b1;
            BR_JALR: br_cond = 1'b1;
            BR_BLT:  br_cond = ($signed(rs1_i) <  $signed(rs2_i));
            BR_BGE:  br_cond = ($signed(rs1_i) >= $signed(rs2_i));
            BR_BLTU: br_cond = (rs1_i <  rs2_i);
            BR_BGEU: br_cond = (rs1_i >= rs2_i);
            default: br_cond = 1'b0;
        endcase
    end

    assign abs_a   = (signed_div && op_a[XLEN-1]) ? (~op_a + XLEN'(1)) : op_a;
    assign abs_b   = (signed_div && op_b[XLEN-1]) ? (~op_b + XLEN'(1)) : op_b;
    assign r_shift = {rem_q, quo_q[XLEN-1]};
    assign r_ge    = (r_shift >= {1'b0, dvsr_q});
    assign r_sub   = XLEN'(r_shift - {1'b0, dvsr_q});

    // Divide-by-zero keeps quotient all-ones since the negate flag is cleared for it.
    assign div_res = is_rem ? (rneg_q ? (~rem_q + XLEN'(1)) : rem_q)
                            : (qneg_q ? (~quo_q + XLEN'(1)) : quo_q);

    // Divider next state.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        dvsr_d  = dvsr_q;
        qneg_d  = qneg_q;
        rneg_d  = rneg_q;
        case (state_q)
            S_IDLE: begin
                if (is_div) begin
                    quo_d   = abs_a;
                    dvsr_d  = abs_b;
                    rem_d   = '0;
                    count_d = '0;
                    qneg_d  = signed_div && (op_a[XLEN-1] ^ op_b[XLEN-1]) && (op_b != '0);
                    rneg_d  = signed_div && op_a[XLEN-1];
                    state_d = S_BUSY;
                end
            end
            S_BUSY: begin
                rem_d   = r_ge ? r_sub : r_shift[XLEN-1:0];
                quo_d   = {quo_q[XLEN-2:0], r_ge};
                count_d = count_q + CNT_W'(1);
                if (count_q == CNT_W'(31)) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // EX/MEM payload; a stall cycle loads an all-zero bubble.
    always_comb begin
        alu_result_d  = is_link ? (pc_i + XLEN'(4)) : alu_val;
        br_target_d   = (br_op_i == BR_JALR) ? ((rs1_i + imm_i) & ~XLEN'(1)) : (pc_i + imm_i);
        store_data_d  = rs2_i;
        lsu_op_d      = lsu_op_i;
        data_dest_d   = data_dest_i;
        reg_wr_addr_d = reg_wr_addr_i;
        reg_wr_sig_d  = reg_wr_sig_i;
        mem_wr_sig_d  = mem_wr_sig_i;
        br_taken_d    = br_sig_i && br_cond;
        if (state_q == S_DONE) begin
            alu_result_d = div_res;
        end
        if (stall_o) begin
            alu_result_d  = '0;
            br_target_d   = '0;
            store_data_d  = '0;
            lsu_op_d      = '0;
            data_dest_d   = '0;
            reg_wr_addr_d = '0;
            reg_wr_sig_d  = 1'b0;
            mem_wr_sig_d  = 1'b0;
            br_taken_d    = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= S_IDLE;
            count_q       <= '0;
            quo_q         <= '0;
            rem_q         <= '0;
            dvsr_q        <= '0;
            qneg_q        <= 1'b0;
            rneg_q        <= 1'b0;
            alu_result_o  <= '0;
            store_data_o  <= '0;
            lsu_op_o      <= '0;
            data_dest_o   <= '0;
            reg_wr_addr_o <= '0;
            reg_wr_sig_o  <= 1'b0;
            mem_wr_sig_o  <= 1'b0;
            br_taken_o    <= 1'b0;
            br_target_o   <= '0;
        end else begin
            state_q       <= state_d;
            count_q       <= count_d;
            quo_q         <= quo_d;
            rem_q         <= rem_d;
            dvsr_q        <= dvsr_d;
            qneg_q        <= qneg_d;
            rneg_q        <= rneg_d;
            alu_result_o  <= alu_result_d;
            store_data_o  <= store_data_d;
            lsu_op_o      <= lsu_op_d;
            data_dest_o   <= data_dest_d;
            reg_wr_addr_o <= reg_wr_addr_d;
            reg_wr_sig_o  <= reg_wr_sig_d;
            mem_wr_sig_o  <= mem_wr_sig_d;
            br_taken_o    <= br_taken_d;
            br_target_o   <= br_target_d;
        end
    end

endmodule

// File: tb/tb_ex_stage.sv
// Directed self-checking bench for ex_stage: ALU ops, branches, divider timing and
// corner cases, and reset during a divide.
module tb_ex_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] pc_i, rs1_i, rs2_i, imm_i;
    logic        br_sig_i;
    logic [2:0]  br_op_i, lsu_op_i;
    logic [4:0]  alu_op_i, reg_wr_addr_i;
    logic [1:0]  data_origin_i, data_dest_i;
    logic        reg_wr_sig_i, mem_wr_sig_i;
    logic        stall_o;
    logic [31:0] alu_result_o, store_data_o, br_target_o;
    logic [2:0]  lsu_op_o;
    logic [1:0]  data_dest_o;
    logic [4:0]  reg_wr_addr_o;
    logic        reg_wr_sig_o, mem_wr_sig_o, br_taken_o;

    int checks = 0;
    int errors = 0;

    ex_stage #(.DIV_ENABLE(1'b1)) dut (
        .clk(clk), .reset(reset),
        .pc_i(pc_i), .rs1_i(rs1_i), .rs2_i(rs2_i),
        .br_sig_i(br_sig_i), .br_op_i(br_op_i), .lsu_op_i(lsu_op_i),
        .alu_op_i(alu_op_i), .data_origin_i(data_origin_i), .data_dest_i(data_dest_i),
        .imm_i(imm_i), .reg_wr_addr_i(reg_wr_addr_i), .reg_wr_sig_i(reg_wr_sig_i),
        .mem_wr_sig_i(mem_wr_sig_i), .stall_o(stall_o),
        .alu_result_o(alu_result_o), .store_data_o(store_data_o), .lsu_op_o(lsu_op_o),
        .data_dest_o(data_dest_o), .reg_wr_addr_o(reg_wr_addr_o),
        .reg_wr_sig_o(reg_wr_sig_o), .mem_wr_sig_o(mem_wr_sig_o),
        .br_taken_o(br_taken_o), .br_target_o(br_target_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic set_bubble();
        pc_i = '0; rs1_i = '0; rs2_i = '0; imm_i = '0;
        br_sig_i = 1'b0; br_op_i = '0; lsu_op_i = '0; alu_op_i = '0;
        data_origin_i = '0; data_dest_i = '0; reg_wr_addr_i = '0;
        reg_wr_sig_i = 1'b0; mem_wr_sig_i = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_alu(input string tag, input logic [4:0] op, input logic [1:0] orig,
                           input logic [31:0] pc, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] imm, input logic [31:0] exp);
        set_bubble();
        alu_op_i = op; data_origin_i = orig; pc_i = pc; rs1_i = a; rs2_i = b; imm_i = imm;
        reg_wr_sig_i = 1'b1; reg_wr_addr_i = 5'd7;
        #1 check({tag, "_stall"}, 32'(stall_o), 32'd0);
        step();
        check(tag, alu_result_o, exp);
    endtask

    task automatic run_br(input string tag, input logic [2:0] bop, input logic bsig,
                          input logic [31:0] pc, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] imm, input logic exp_taken, input logic [31:0] exp_tgt);
        set_bubble();
        br_sig_i = bsig; br_op_i = bop; pc_i = pc; rs1_i = a; rs2_i = b; imm_i = imm;
        step();
        check({tag, "_taken"}, 32'(br_taken_o), 32'(exp_taken));
        if (exp_taken) check({tag, "_target"}, br_target_o, exp_tgt);
    endtask

    // Holds the divide instruction while stall_o is high, as the upstream stages would.
    task automatic run_div(input string tag, input logic [4:0] op, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] exp);
        int stalls = 0;
        int edges = 0;
        int bad_bubbles = 0;
        logic s;
        set_bubble();
        alu_op_i = op; rs1_i = a; rs2_i = b; reg_wr_sig_i = 1'b1; reg_wr_addr_i = 5'd9;
        mem_wr_sig_i = 1'b0;
        #1;
        for (int i = 0; i < 40; i++) begin
            s = stall_o;
            step();
            edges++;
            if (!s) break;
            stalls++;
            if (reg_wr_sig_o || mem_wr_sig_o || br_taken_o) bad_bubbles++;
        end
        check({tag, "_stalls"}, 32'(stalls), 32'd33);
        check({tag, "_latency"}, 32'(edges), 32'd34);
        check({tag, "_bubbles"}, 32'(bad_bubbles), 32'd0);
        check({tag, "_result"}, alu_result_o, exp);
        check({tag, "_wr_sig"}, 32'(reg_wr_sig_o), 32'd1);
        check({tag, "_rd"}, 32'(reg_wr_addr_o), 32'd9);
        set_bubble();
    endtask

    initial begin
        set_bubble();
        reset = 1'b1;
        #12;
        check("rst_alu", alu_result_o, 32'd0);
        check("rst_wr", 32'(reg_wr_sig_o), 32'd0);
        check("rst_taken", 32'(br_taken_o), 32'd0);
        check("rst_stall", 32'(stall_o), 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // ADD with immediate operand
        set_bubble();
        rs1_i = 32'd5; imm_i = 32'hFFFF_FFFD; data_origin_i = 2'b01;
        reg_wr_sig_i = 1'b1; reg_wr_addr_i = 5'd3; rs2_i = 32'hDEAD_BEEF;
        #1 check("add_stall", 32'(stall_o), 32'd0);
        step();
        check("add_result", alu_result_o, 32'd2);
        check("add_rd", 32'(reg_wr_addr_o), 32'd3);
        check("add_wr", 32'(reg_wr_sig_o), 32'd1);
        check("add_store", store_data_o, 32'hDEAD_BEEF);

        run_alu("sub",  5'd1,  2'b00, 0, 32'hF000_0010, 32'd4, 0, 32'hF000_000C);
        run_alu("sll",  5'd2,  2'b00, 0, 32'hF000_0010, 32'd4, 0, 32'h0000_0100);
        run_alu("slt",  5'd3,  2'b00, 0, 32'hF000_0010, 32'd4, 0, 32'd1);
        run_alu("sltu", 5'd4,  2'b00, 0, 32'hF000_0010, 32'd4, 0, 32'd0);
        run_alu("xor",  5'd5,  2'b00, 0, 32'hF000_0010, 32'd4, 0, 32'hF000_0014);
        run_alu("srl",  5'd6,  2'b00, 0, 32'hF000_0010, 32'd4, 0, 32'h0F00_0001);
        run_alu("sra",  5'd7,  2'b00, 0, 32'hF000_0010, 32'd4, 0, 32'hFF00_0001);
        run_alu("or",   5'd8,  2'b00, 0, 32'hF000_0010, 32'd4, 0, 32'hF000_0014);
        run_alu("and",  5'd9,  2'b00, 0, 32'hF000_0010, 32'd4, 0, 32'h0000_0000);
        run_alu("pass", 5'd10, 2'b00, 0, 32'hF000_0010, 32'd4, 0, 32'd4);
        run_alu("inv",  5'd11, 2'b00, 0, 32'hF000_0010, 32'd4, 0, 32'd0);
        run_alu("sra33",5'd7,  2'b00, 0, 32'h8000_0000, 32'd33, 0, 32'hC000_0000);
        run_alu("auipc",5'd0,  2'b11, 32'h1000, 32'd77, 32'd88, 32'h2000, 32'h3000);

        run_br("blt",  3'd4, 1'b1, 32'h100, 32'hFFFF_FFFF, 32'd1, 32'h20, 1'b1, 32'h120);
        run_br("bltu", 3'd6, 1'b1, 32'h100, 32'hFFFF_FFFF, 32'd1, 32'h20, 1'b0, 32'h0);
        run_br("beq",  3'd0, 1'b1, 32'h200, 32'd3, 32'd3, 32'hFFFF_FFF0, 1'b1, 32'h1F0);
        run_br("bne",  3'd1, 1'b1, 32'h200, 32'd3, 32'd3, 32'h8, 1'b0, 32'h0);
        run_br("bge0", 3'd5, 1'b0, 32'h200, 32'd5, 32'd3, 32'h8, 1'b0, 32'h0);

        // JALR: target clears bit 0, result is the link address
        set_bubble();
        br_sig_i = 1'b1; br_op_i = 3'd3; rs1_i = 32'h1003; imm_i = 32'd4; pc_i = 32'h40;
        data_origin_i = 2'b01; reg_wr_sig_i = 1'b1; reg_wr_addr_i = 5'd1;
        step();
        check("jalr_target", br_target_o, 32'h1006);
        check("jalr_link", alu_result_o, 32'h44);
        check("jalr_taken", 32'(br_taken_o), 32'd1);

        run_div("divu", 5'd15, 32'd100, 32'd7, 32'd14);
        run_div("remu", 5'd17, 32'd100, 32'd7, 32'd2);
        run_div("div0", 5'd14, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFFF);
        run_div("rem0", 5'd16, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9);
        run_div("remov",5'd16, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0);
        run_div("divov",5'd14, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
        run_div("divn", 5'd14, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD);
        run_div("remn", 5'd16, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF);

        // Back-to-back ADD after a divide completes in one cycle
        run_alu("postdiv", 5'd0, 2'b00, 0, 32'd10, 32'd20, 0, 32'd30);

        // Reset during BUSY, step 10
        set_bubble();
        alu_op_i = 5'd15; rs1_i = 32'd1000; rs2_i = 32'd3; reg_wr_sig_i = 1'b1;
        for (int i = 0; i < 11; i++) step();
        check("mid_stall", 32'(stall_o), 32'd1);
        reset = 1'b1;
        #1;
        check("mrst_stall", 32'(stall_o), 32'd0);
        check("mrst_alu", alu_result_o, 32'd0);
        check("mrst_wr", 32'(reg_wr_sig_o), 32'd0);
        set_bubble();
        rs1_i = 32'd40; rs2_i = 32'd2; reg_wr_sig_i = 1'b1; reg_wr_addr_i = 5'd4;
        @(negedge clk);
        reset = 1'b0;
        #1 check("prst_stall", 32'(stall_o), 32'd0);
        step();
        check("prst_add", alu_result_o, 32'd42);
        check("prst_rd", 32'(reg_wr_addr_o), 32'd4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
